// File: rtl/vector_output_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vector_output_buffer_if : drain-side valid/ready bus of the output buffer  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface vector_output_buffer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int VECTOR_SIZE = 6,
    parameter int LANE_W      = $clog2(VECTOR_SIZE)
);
    logic                              drainValid;
    logic                              drainReady;
    logic [DATA_WIDTH*VECTOR_SIZE-1:0] drainData;
    logic [LANE_W-1:0]                 drainLane;
    logic                              drainLast;

    modport master (
        output drainValid,
        output drainData,
        output drainLane,
        output drainLast,
        input  drainReady
    );

    modport slave (
        input  drainValid,
        input  drainData,
        input  drainLane,
        input  drainLast,
        output drainReady
    );
endinterface
`default_nettype wire

// File: rtl/vector_output_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vector_output_buffer : captures CPU result vectors into a FIFO and drains  |
// | them as whole-vector or lane-per-beat valid/ready transfers.               |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module vector_output_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int VECTOR_SIZE = 6,
    parameter int DEPTH       = 8,
    parameter int LANE_W      = $clog2(VECTOR_SIZE),
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  wire logic                              clock,
    input  wire logic                              reset,
    input  wire logic                              outFlag,
    input  wire logic [DATA_WIDTH*VECTOR_SIZE-1:0] out,
    input  wire logic                              serialMode,
    input  wire logic                              clear,
    vector_output_buffer_if.master                 drain,
    output logic      [CNT_W-1:0]                  count,
    output logic                                   full,
    output logic                                   empty,
    output logic                                   overflow,
    output logic      [7:0]                        dropCount
);

    localparam int                PTR_W       = $clog2(DEPTH);
    localparam int                VEC_W       = DATA_WIDTH * VECTOR_SIZE;
    localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(VECTOR_SIZE - 1);
    localparam logic [CNT_W-1:0]  C_DEPTH     = CNT_W'(DEPTH);

    logic [VEC_W-1:0]      mem_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic                  mode_q, mode_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_q, drop_d;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_last;
    logic                  w_xfer;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_drop;
    logic [VEC_W-1:0]      w_head;
    logic [DATA_WIDTH-1:0] w_lane_data;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == C_DEPTH);
    assign w_last  = mode_q ? (lane_q == C_LAST_LANE) : 1'b1;
    assign w_xfer  = !w_empty && drain.drainReady;
    assign w_pop   = w_xfer && w_last;

    // A final-beat pop frees a slot at the same edge, so a full FIFO can still accept.
    assign w_capture = outFlag && !clear && (!w_full || w_pop);
    assign w_drop    = outFlag && !clear && w_full && !w_pop;

    assign w_head = mem_q[rd_ptr_q];

    always_comb begin
        w_lane_data = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            if (lane_q == LANE_W'(i)) begin
                w_lane_data = w_head[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        lane_d     = lane_q;
        mode_d     = mode_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (w_capture) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (w_xfer) begin
            lane_d = w_last ? '0 : lane_q + LANE_W'(1);
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({w_capture, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Mode only changes on an entry boundary so a serial entry is never split.
        if (w_empty || w_pop) begin
            mode_d = serialMode;
        end

        if (w_drop) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            lane_d     = '0;
            mode_d     = serialMode;
            overflow_d = 1'b0;
            drop_d     = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lane_q     <= '0;
            mode_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lane_q     <= lane_d;
            mode_q     <= mode_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage is deliberately left unreset; occupancy alone qualifies its contents.
    always_ff @(posedge clock) begin
        if (w_capture) begin
            mem_q[wr_ptr_q] <= out;
        end
    end

    always_comb begin
        drain.drainValid = !w_empty;
        drain.drainLast  = w_last;
        drain.drainLane  = mode_q ? lane_q : '0;
        if (w_empty) begin
            drain.drainData = '0;
        end else if (mode_q) begin
            drain.drainData = VEC_W'(w_lane_data);
        end else begin
            drain.drainData = w_head;
        end
    end

    assign count     = count_q;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = overflow_q;
    assign dropCount = drop_q;

endmodule
`default_nettype wire
